// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer that paces the soft CPU with one-cycle clock-enable pulses.
// Conditions the run switch and step button, tracks breakpoints and counts issued CPU cycles.
module cpu_clk_ctrl #(
  parameter int unsigned DIV        = 100000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic        I_CLK,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } state_e;

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          run_meta_q, run_s_q;
  logic          btn_meta_q, btn_s_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_lvl_q, deb_lvl_d;
  logic          deb_lvl_prev_q;
  logic          step_ev;
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic [31:0]   cycle_cnt_q;

  // Two-flop synchronizers for the asynchronous switch and button, plus the debouncer.
  // NOTE: every sequential block uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      run_meta_q     <= 1'b0;
      run_s_q        <= 1'b0;
      btn_meta_q     <= 1'b0;
      btn_s_q        <= 1'b0;
      deb_cnt_q      <= '0;
      deb_lvl_q      <= 1'b0;
      deb_lvl_prev_q <= 1'b0;
    end else begin
      run_meta_q     <= run_sw;
      run_s_q        <= run_meta_q;
      btn_meta_q     <= step_btn;
      btn_s_q        <= btn_meta_q;
      deb_cnt_q      <= deb_cnt_d;
      deb_lvl_q      <= deb_lvl_d;
      deb_lvl_prev_q <= deb_lvl_q;
    end
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    if (btn_s_q == deb_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_lvl_d = btn_s_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  assign step_ev = deb_lvl_q & ~deb_lvl_prev_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT: begin
        if (run_s_q)      state_d = S_RUN;
        else if (step_ev) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_req)      state_d = S_BRK;
        else if (!run_s_q) state_d = S_HALT;
      end
      S_STEP: state_d = S_HALT;
      S_BRK: begin
        if (!run_s_q)     state_d = S_HALT;
        else if (step_ev) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase

    // Prescaler only advances while staying in RUN; anything else restarts the period.
    pre_d = '0;
    if (state_q == S_RUN && state_d == S_RUN) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    cpu_ce_d = ((state_q == S_RUN) && (pre_q == PRE_LAST) && !halt_req && run_s_q)
               || (state_d == S_STEP);
  end

  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      pre_q       <= '0;
      cpu_ce_q    <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cpu_ce_q    <= cpu_ce_d;
      cycle_cnt_q <= cycle_cnt_q + 32'(cpu_ce_q);
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: scenario tasks with expectations derived from
// pulse-timing arithmetic and a running pulse-count scoreboard.
module tb_cpu_clk_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = '0;
  logic        prev_ce = 1'b0;

  cpu_clk_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .I_CLK    (clk),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample on the falling edge and run the per-cycle scoreboard.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst) exp_cnt = '0;
    else     exp_cnt = exp_cnt + 32'(prev_ce);
    compared++;
    if (cycle_cnt !== exp_cnt) begin
      mismatched++;
      $display("FAIL cnt_track cyc=%0d: got %h expected %h", cyc, cycle_cnt, exp_cnt);
    end
    compared++;
    if ((cpu_ce && !(state == S_RUN || state == S_STEP)) || (state == S_STEP && cpu_ce !== 1'b1)) begin
      mismatched++;
      $display("FAIL ce_state cyc=%0d: ce=%b state=%b", cyc, cpu_ce, state);
    end
    compared++;
    if (prev_ce && cpu_ce) begin
      mismatched++;
      $display("FAIL ce_width cyc=%0d: cpu_ce high two cycles in a row", cyc);
    end
    prev_ce = rst ? 1'b0 : cpu_ce;
  endtask

  task automatic expect_state(input string name, input logic [1:0] exp);
    compared++;
    if (state !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: state got %b expected %b", name, cyc, state, exp);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic wait_pulse(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cpu_ce) begin
        at = cyc;
        break;
      end
    end
    compared++;
    if (at < 0) begin
      mismatched++;
      $display("FAIL wait_pulse cyc=%0d: no cpu_ce within %0d cycles", cyc, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    expect_state("reset_state", S_HALT);
    expect_int("reset_ce", int'(cpu_ce), 0);
    expect_int("reset_cnt", int'(cycle_cnt), 0);
    rst = 1'b0;
    repeat (4) tick();
    expect_state("idle_halt", S_HALT);
  endtask

  task automatic test_run();
    int x, r, prev, at;
    run_sw = 1'b1;
    x = cyc;
    tick(); tick();
    expect_state("run_entry_early", S_HALT);
    tick();
    expect_state("run_entry", S_RUN);
    r = cyc;
    prev = r;
    for (int k = 1; k <= 10; k++) begin
      wait_pulse(2 * DIV, at);
      expect_int("run_spacing", at - prev, DIV);
      prev = at;
    end
    tick();
    expect_int("run_cnt10", int'(cycle_cnt), 10);
    run_sw = 1'b0;
    repeat (3) tick();
    expect_state("run_exit", S_HALT);
    if (x < 0) $display("unreachable");
  endtask

  // Random RUN windows: pulses land at entry+k*DIV, and the switch drop takes effect
  // three cycles later, so the pulse count is floor((L+2)/DIV).
  task automatic test_run_random();
    int r, d, len, pulses;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 5)) tick();
      run_sw = 1'b1;
      repeat (3) tick();
      expect_state("rnd_entry", S_RUN);
      r = cyc;
      len = $urandom_range(DIV, 6 * DIV);
      pulses = 0;
      for (int i = 0; i < len + 3; i++) begin
        if (i == len) begin
          d = cyc;
          run_sw = 1'b0;
        end
        tick();
        if (cpu_ce) begin
          pulses++;
          expect_int("rnd_phase", (cyc - r) % DIV, 0);
        end
      end
      expect_state("rnd_exit", S_HALT);
      expect_int("rnd_pulses", pulses, (d + 2 - r) / DIV);
    end
  endtask

  task automatic test_step();
    int pulses = 0, steps = 0;
    logic [31:0] base;
    base = exp_cnt;
    for (int seg = 0; seg < 4; seg++) begin
      step_btn = (seg % 2 == 0);
      repeat ($urandom_range(1, 2)) begin
        tick();
        pulses += int'(cpu_ce);
        steps  += int'(state == S_STEP);
      end
    end
    step_btn = 1'b1;
    repeat (14) begin
      tick();
      pulses += int'(cpu_ce);
      steps  += int'(state == S_STEP);
    end
    expect_int("step_pulses", pulses, 1);
    expect_int("step_states", steps, 1);
    expect_state("step_back_halt", S_HALT);
    compared++;
    if (cycle_cnt !== base + 32'd1) begin
      mismatched++;
      $display("FAIL step_cnt: got %h expected %h", cycle_cnt, base + 32'd1);
    end
    step_btn = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(cpu_ce);
    end
    expect_int("release_pulses", pulses, 0);
  endtask

  task automatic test_halt_req();
    int r, k, pulses = 0, bad = 0;
    run_sw = 1'b1;
    repeat (3) tick();
    expect_state("brk_run", S_RUN);
    r = cyc;
    k = $urandom_range(1, 3);
    while (cyc < r + DIV * (k + 1) - 1) begin
      tick();
      pulses += int'(cpu_ce);
    end
    expect_int("brk_pre_pulses", pulses, k);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    expect_int("brk_suppress", int'(cpu_ce), 0);
    expect_state("brk_enter", S_BRK);
    pulses = 0;
    repeat (12) begin
      tick();
      pulses += int'(cpu_ce);
      bad    += int'(state != S_BRK);
    end
    expect_int("brk_hold_pulses", pulses, 0);
    expect_int("brk_hold_state", bad, 0);
    run_sw = 1'b0;
    tick(); tick();
    expect_state("brk_exit_early", S_BRK);
    tick();
    expect_state("brk_exit", S_HALT);
  endtask

  task automatic test_brk_step();
    int found = 0, pulses = 0, prev = -1, gaps_bad = 0, n = 0;
    run_sw = 1'b1;
    repeat (3 + $urandom_range(0, 7)) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    expect_state("bs_brk", S_BRK);
    step_btn = 1'b1;
    for (int i = 0; i < 15 && found == 0; i++) begin
      tick();
      if (state == S_STEP) found = 1;
      else pulses += int'(cpu_ce);
    end
    expect_int("bs_step_seen", found, 1);
    expect_int("bs_step_ce", int'(cpu_ce), 1);
    expect_int("bs_no_early_pulse", pulses, 0);
    tick();
    expect_state("bs_after_step", S_HALT);
    expect_int("bs_after_ce", int'(cpu_ce), 0);
    tick();
    expect_state("bs_resume_run", S_RUN);
    step_btn = 1'b0;
    repeat (6) tick();
    step_btn = 1'b1;
    repeat (24) begin
      tick();
      if (cpu_ce) begin
        n++;
        if (prev >= 0 && cyc - prev != DIV) gaps_bad++;
        prev = cyc;
      end
      if (state != S_RUN) gaps_bad++;
    end
    expect_int("run_step_ignored", gaps_bad, 0);
    expect_int("run_step_pulses", n, 24 / DIV);
    step_btn = 1'b0;
    run_sw = 1'b0;
    repeat (8) tick();
    expect_state("bs_done", S_HALT);
  endtask

  // Run switch and debounced step edge land on the same evaluation cycle.
  task automatic test_run_step_same();
    int x, bad = 0;
    step_btn = 1'b1;
    x = cyc;
    repeat (3) tick();
    run_sw = 1'b1;
    while (cyc < x + 9) begin
      tick();
      bad += int'(cpu_ce) + int'(state == S_STEP);
      if (cyc == x + 6) expect_state("same_run", S_RUN);
    end
    expect_int("same_no_extra", bad, 0);
    tick();
    expect_int("same_first_pulse", int'(cpu_ce), 1);
    run_sw = 1'b0;
    step_btn = 1'b0;
    repeat (10) tick();
    expect_state("same_done", S_HALT);
  endtask

  task automatic test_wrap_reset();
    int at, z, early = 0;
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    prev_ce = 1'b0;
    tick();
    compared++;
    if (cycle_cnt !== 32'hFFFF_FFFE) begin
      mismatched++;
      $display("FAIL preload: got %h expected fffffffe", cycle_cnt);
    end
    run_sw = 1'b1;
    wait_pulse(3 + 2 * DIV, at);
    wait_pulse(2 * DIV, at);
    tick();
    compared++;
    if (cycle_cnt !== 32'd0) begin
      mismatched++;
      $display("FAIL wrap: got %h expected 00000000", cycle_cnt);
    end
    tick();
    rst = 1'b1;
    #1;
    expect_state("async_rst_state", S_HALT);
    expect_int("async_rst_ce", int'(cpu_ce), 0);
    expect_int("async_rst_cnt", int'(cycle_cnt), 0);
    tick(); tick();
    rst = 1'b0;
    z = cyc;
    while (cyc < z + DIV + 2) begin
      tick();
      early += int'(cpu_ce);
      if (cyc == z + 2) expect_state("rst_resync", S_HALT);
      if (cyc == z + 3) expect_state("rst_rerun", S_RUN);
    end
    expect_int("rst_no_pulse", early, 0);
    tick();
    expect_int("rst_first_pulse", int'(cpu_ce), 1);
    run_sw = 1'b0;
    repeat (4) tick();
    expect_state("wrap_done", S_HALT);
  endtask

  initial begin
    test_reset();
    test_run();
    test_run_random();
    test_step();
    test_halt_req();
    test_brk_step();
    test_run_step_same();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
